cpu_ex_md: RTL and testbench
============================

# cpu_ex_md

Parametrised execute stage for the PLP CPU: ALU, shifter and address adder, plus an iterative multiply/divide unit with internal HI/LO registers. Sits between decode and memory stages, registers its results into the EX/MEM pipeline register, and raises a structural-hazard stall toward fetch/decode while an in-flight multiply/divide blocks a dependent instruction.

## Interface
- `XLEN`, 32: datapath width; must be ≥8 and a power of two.
- `SHW`, $clog2(XLEN): shift-amount width.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall_in` in 1: downstream stall; EX/MEM register holds.
- `id_valid` in 1: decode stage presents an instruction.
- `id_c_rfw`, `id_c_drw` in 1 each; `id_c_wbsource` in 2; `id_c_alucontrol` in 6; `id_func` in 6.
- `id_rfa`, `id_rfb`, `id_rfbse`, `id_jalra` in XLEN; `id_shamt` in SHW; `id_rf_waddr` in 5.
- `ex_stall` out 1: upstream must hold `id_*` stable.
- `p_valid`, `p_c_rfw`, `p_c_drw` out 1; `p_c_wbsource` out 2; `p_alu_r`, `p_rfb`, `p_jalra` out XLEN; `p_rf_waddr` out 5.
- `md_busy` out 1: multiply/divide unit iterating (debug/perf counter).

## Operation
- alucontrol 0x00 selects `id_func`. Otherwise it is mapped: 0x08/0x09/0x23/0x2b→add, 0x0c→and, 0x0d→or, 0x0a→slt, 0x0b→sltu, 0x0f (lui)→`y << 16`.
- R-type funcs: 0x21 add, 0x23 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2a slt, 0x2b sltu, 0x00 sll, 0x02 srl, 0x03 sra, 0x04 sllv, 0x06 srlv, 0x07 srav. Variable shifts use `rfa[SHW-1:0]` as the amount and `rfb` as the operand. Unknown funcs produce 0.
- slt compares signed; sltu compares unsigned. The result is zero-extended to XLEN.
- Multiply/divide funcs: 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu. They issue to the unit, latch operands, and pass down the pipe with `p_c_rfw`=0.
- 0x10 mfhi and 0x12 mflo place HI or LO on `p_alu_r`.
- Unit FSM: IDLE → RUN (XLEN cycles, one shift-add or restoring-subtract step per cycle) → FIX (one cycle: signed result negation, HI/LO write) → IDLE.
- Signed ops iterate on magnitudes.
- Divide by zero: LO = all ones, HI = dividend; no trap.
- Signed overflow (−2^(XLEN−1) / −1): LO = dividend, HI = 0.
- Interlock: `ex_stall`=1 when `id_valid` and the instruction is mfhi/mflo/mult/div/multu/divu while the FSM is not IDLE. While stalled, EX/MEM captures a bubble: `p_valid`=0 and all `p_c_*`=0.
- `stall_in`=1: EX/MEM holds its value and `ex_stall`=1. The FSM keeps iterating. A new multiply/divide is not issued while `stall_in`=1.

## Timing
- Reset values: all `p_*` = 0, HI = LO = 0, FSM IDLE, `ex_stall` = 0, `md_busy` = 0.
- Reset asserted mid-iteration aborts the operation; HI/LO return to 0.
- ALU path latency is one cycle: `id_*` at edge N appear on `p_*` after edge N.
- Multiply/divide issued at edge N: `md_busy` is high from N+1 to N+XLEN+1. HI/LO are written at edge N+XLEN+1.
- An mfhi presented at N+1 stalls through edge N+XLEN+1 and is captured at edge N+XLEN+2 with the new value.
- mfhi/mflo in the same cycle the FIX write occurs is stalled; no bypass.
- `ex_stall` is combinational from the FSM state, `id_valid`, `id_func`, `id_c_alucontrol` and `stall_in`.

## Configuration
- `CPU_EX_DIV_EN` defined: the divider datapath and div/divu are compiled in.
- `CPU_EX_DIV_EN` undefined: div/divu execute as no-ops. HI/LO are unchanged, there is no stall, and `p_c_rfw`=0. Multiply is unaffected.

## Structure
- Package `cpu_pkg` holds the func and alucontrol codes as localparams, the ALU-op enum, the FSM state enum, and the `wbsource` encodings.
- Sub-module `cpu_md_iter` contains the FSM, operand/accumulator registers, HI/LO and the `CPU_EX_DIV_EN` guard.
- The top-level contains ALU decode, shifter, interlock logic and the EX/MEM register.

## Test plan
- Reset released, add of 5 and 7 (func 0x21) → `p_alu_r`=12 and `p_valid`=1 after one edge. Check all `p_*` are 0 during reset.
- sra of 0x8000_0000 by 4 → 0xF800_0000. srlv with `rfa`=36 → shift by 4 (masked).
- mult of −3 × 7, then immediately mfhi and mflo → `ex_stall` high for XLEN+1 cycles. Results: HI=0xFFFF_FFFF, LO=0xFFFF_FFEB.
- div 7 / 0 → LO=0xFFFF_FFFF, HI=7. Signed div of 0x8000_0000 by −1 → LO=0x8000_0000, HI=0.
- `rst` pulsed at cycle 10 of a divu → FSM IDLE, HI=LO=0, `ex_stall`=0 on the next edge.
- Build without `CPU_EX_DIV_EN`: div issued → no stall and HI/LO unchanged. A subsequent mult still produces a correct result.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op and state encodings for the PLP execute stage.
package cpu_pkg;

    localparam logic [5:0] AC_RTYPE  = 6'h00;
    localparam logic [5:0] AC_ADDI   = 6'h08;
    localparam logic [5:0] AC_ADDIU  = 6'h09;
    localparam logic [5:0] AC_SLTI   = 6'h0a;
    localparam logic [5:0] AC_SLTIU  = 6'h0b;
    localparam logic [5:0] AC_ANDI   = 6'h0c;
    localparam logic [5:0] AC_ORI    = 6'h0d;
    localparam logic [5:0] AC_LUI    = 6'h0f;
    localparam logic [5:0] AC_LW     = 6'h23;
    localparam logic [5:0] AC_SW     = 6'h2b;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1a;
    localparam logic [5:0] FUNC_DIVU  = 6'h1b;
    localparam logic [5:0] FUNC_ADD   = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2a;
    localparam logic [5:0] FUNC_SLTU  = 6'h2b;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef enum logic [4:0] {
        OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_LUI,
        OP_MFHI, OP_MFLO
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE, MD_RUN, MD_FIX
    } md_state_e;

endpackage

// File: rtl/cpu_md_iter.sv
// Iterative multiply/divide unit with HI/LO; divider built only when CPU_EX_DIV_EN is defined.
module cpu_md_iter
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      func,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            div_en_c
);

    localparam int unsigned CW = $clog2(XLEN);

    md_state_e         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   acc, mq, dsr;
    logic              neg_q;
    logic              is_mul, is_sgn, accept;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod;

    assign is_mul  = (func == FUNC_MULT) || (func == FUNC_MULTU);
    assign is_sgn  = (func == FUNC_MULT) || (func == FUNC_DIV);
    assign a_mag   = (is_sgn && a[XLEN-1]) ? -a : a;
    assign b_mag   = (is_sgn && b[XLEN-1]) ? -b : b;
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, dsr} : {(XLEN+1){1'b0}});
    assign prod    = {acc, mq};

`ifdef CPU_EX_DIV_EN
    logic            is_div, op_div, neg_r, ge;
    logic [XLEN:0]   shl;
    logic [XLEN-1:0] sub;
    assign is_div   = (func == FUNC_DIV) || (func == FUNC_DIVU);
    assign shl      = {acc, mq[XLEN-1]};
    assign ge       = shl >= {1'b0, dsr};
    assign sub      = XLEN'(shl - {1'b0, dsr});
    assign div_en_c = 1'b1;
`else
    logic is_div;
    assign is_div   = 1'b0;
    assign div_en_c = 1'b0;
`endif

    assign accept = start && (is_mul || is_div);
    assign busy   = (state != MD_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == CW'(XLEN-1)) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Operands iterate as magnitudes; signs are reapplied in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            mq     <= '0;
            dsr    <= '0;
            neg_q  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef CPU_EX_DIV_EN
            op_div <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                MD_IDLE: if (accept) begin
                    cnt   <= '0;
                    acc   <= '0;
                    mq    <= a_mag;
                    dsr   <= b_mag;
                    neg_q <= is_sgn && (a[XLEN-1] ^ b[XLEN-1]);
`ifdef CPU_EX_DIV_EN
                    op_div <= is_div;
                    neg_r  <= is_sgn && a[XLEN-1];
`endif
                end
                MD_RUN: begin
                    cnt <= cnt + CW'(1);
`ifdef CPU_EX_DIV_EN
                    if (op_div) begin
                        acc <= ge ? sub : shl[XLEN-1:0];
                        mq  <= {mq[XLEN-2:0], ge};
                    end else
`endif
                    begin
                        acc <= mul_sum[XLEN:1];
                        mq  <= {mul_sum[0], mq[XLEN-1:1]};
                    end
                end
                MD_FIX: begin
`ifdef CPU_EX_DIV_EN
                    // Zero divisor leaves quotient all ones and remainder = |dividend|.
                    if (op_div) begin
                        lo <= (neg_q && (dsr != '0)) ? -mq : mq;
                        hi <= neg_r ? -acc : acc;
                    end else
`endif
                    begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_ex_md.sv
// PLP execute stage: ALU/shifter, mul/div interlock and EX/MEM register.
// Optional divider: define CPU_EX_DIV_EN.
module cpu_ex_md
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            id_valid,
    input  logic            id_c_rfw,
    input  logic            id_c_drw,
    input  logic [1:0]      id_c_wbsource,
    input  logic [5:0]      id_c_alucontrol,
    input  logic [5:0]      id_func,
    input  logic [XLEN-1:0] id_rfa,
    input  logic [XLEN-1:0] id_rfb,
    input  logic [XLEN-1:0] id_rfbse,
    input  logic [XLEN-1:0] id_jalra,
    input  logic [SHW-1:0]  id_shamt,
    input  logic [4:0]      id_rf_waddr,
    output logic            ex_stall,
    output logic            p_valid,
    output logic            p_c_rfw,
    output logic            p_c_drw,
    output logic [1:0]      p_c_wbsource,
    output logic [XLEN-1:0] p_alu_r,
    output logic [XLEN-1:0] p_rfb,
    output logic [XLEN-1:0] p_jalra,
    output logic [4:0]      p_rf_waddr,
    output logic            md_busy
);

    alu_op_e         op;
    logic [XLEN-1:0] x, y, alu_r, hi, lo;
    logic            rtype, is_mfx, is_mul, is_div, is_md_op;
    logic            md_dep, hazard, md_start, div_en, take;

    assign rtype    = (id_c_alucontrol == AC_RTYPE);
    assign is_mfx   = rtype && ((id_func == FUNC_MFHI) || (id_func == FUNC_MFLO));
    assign is_mul   = rtype && ((id_func == FUNC_MULT) || (id_func == FUNC_MULTU));
    assign is_div   = rtype && ((id_func == FUNC_DIV)  || (id_func == FUNC_DIVU));
    assign is_md_op = is_mul || is_div;

    // A disabled divider makes div/divu plain no-ops with no dependency.
    assign md_dep   = is_mfx || is_mul || (is_div && div_en);
    assign hazard   = id_valid && md_dep && md_busy;
    assign ex_stall = stall_in || hazard;
    assign md_start = id_valid && is_md_op && !ex_stall;
    assign take     = id_valid && !hazard;

    cpu_md_iter #(.XLEN(XLEN)) u_md (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start),
        .func     (id_func),
        .a        (id_rfa),
        .b        (id_rfb),
        .hi       (hi),
        .lo       (lo),
        .busy     (md_busy),
        .div_en_c (div_en)
    );

    always_comb begin
        op = OP_NONE;
        if (rtype) begin
            case (id_func)
                FUNC_ADD:  op = OP_ADD;
                FUNC_SUB:  op = OP_SUB;
                FUNC_AND:  op = OP_AND;
                FUNC_OR:   op = OP_OR;
                FUNC_NOR:  op = OP_NOR;
                FUNC_SLT:  op = OP_SLT;
                FUNC_SLTU: op = OP_SLTU;
                FUNC_SLL:  op = OP_SLL;
                FUNC_SRL:  op = OP_SRL;
                FUNC_SRA:  op = OP_SRA;
                FUNC_SLLV: op = OP_SLLV;
                FUNC_SRLV: op = OP_SRLV;
                FUNC_SRAV: op = OP_SRAV;
                FUNC_MFHI: op = OP_MFHI;
                FUNC_MFLO: op = OP_MFLO;
                default:   op = OP_NONE;
            endcase
        end else begin
            case (id_c_alucontrol)
                AC_ADDI, AC_ADDIU, AC_LW, AC_SW: op = OP_ADD;
                AC_ANDI:  op = OP_AND;
                AC_ORI:   op = OP_OR;
                AC_SLTI:  op = OP_SLT;
                AC_SLTIU: op = OP_SLTU;
                AC_LUI:   op = OP_LUI;
                default:  op = OP_NONE;
            endcase
        end
    end

    assign x = id_rfa;
    assign y = rtype ? id_rfb : id_rfbse;

    always_comb begin
        alu_r = '0;
        case (op)
            OP_ADD:  alu_r = x + y;
            OP_SUB:  alu_r = x - y;
            OP_AND:  alu_r = x & y;
            OP_OR:   alu_r = x | y;
            OP_NOR:  alu_r = ~(x | y);
            OP_SLT:  alu_r = XLEN'($signed(x) < $signed(y));
            OP_SLTU: alu_r = XLEN'(x < y);
            OP_SLL:  alu_r = id_rfb << id_shamt;
            OP_SRL:  alu_r = id_rfb >> id_shamt;
            OP_SRA:  alu_r = $unsigned($signed(id_rfb) >>> id_shamt);
            OP_SLLV: alu_r = id_rfb << id_rfa[SHW-1:0];
            OP_SRLV: alu_r = id_rfb >> id_rfa[SHW-1:0];
            OP_SRAV: alu_r = $unsigned($signed(id_rfb) >>> id_rfa[SHW-1:0]);
            OP_LUI:  alu_r = y << 16;
            OP_MFHI: alu_r = hi;
            OP_MFLO: alu_r = lo;
            default: alu_r = '0;
        endcase
    end

    // EX/MEM register; interlock stalls insert a bubble, downstream stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid      <= 1'b0;
            p_c_rfw      <= 1'b0;
            p_c_drw      <= 1'b0;
            p_c_wbsource <= '0;
            p_alu_r      <= '0;
            p_rfb        <= '0;
            p_jalra      <= '0;
            p_rf_waddr   <= '0;
        end else if (!stall_in) begin
            p_valid      <= take;
            p_c_rfw      <= take && id_c_rfw && !is_md_op;
            p_c_drw      <= take && id_c_drw;
            p_c_wbsource <= take ? id_c_wbsource : 2'd0;
            p_alu_r      <= alu_r;
            p_rfb        <= id_rfb;
            p_jalra      <= id_jalra;
            p_rf_waddr   <= id_rf_waddr;
        end
    end

endmodule

// File: tb/tb_cpu_ex_md.sv
// Scoreboard bench for cpu_ex_md: directed vectors, monitor compares each EX/MEM capture.
module tb_cpu_ex_md;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall_in = 1'b0;
    logic            id_valid = 1'b0;
    logic            id_c_rfw = 1'b0;
    logic            id_c_drw = 1'b0;
    logic [1:0]      id_c_wbsource = 2'd0;
    logic [5:0]      id_c_alucontrol = 6'd0;
    logic [5:0]      id_func = 6'd0;
    logic [XLEN-1:0] id_rfa = '0, id_rfb = '0, id_rfbse = '0, id_jalra = '0;
    logic [SHW-1:0]  id_shamt = '0;
    logic [4:0]      id_rf_waddr = '0;
    logic            ex_stall, p_valid, p_c_rfw, p_c_drw, md_busy;
    logic [1:0]      p_c_wbsource;
    logic [XLEN-1:0] p_alu_r, p_rfb, p_jalra;
    logic [4:0]      p_rf_waddr;

    typedef struct packed {
        logic [31:0] r;
        logic        rfw;
        logic [7:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic upd_q  = 1'b0;

    cpu_ex_md #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .id_valid(id_valid),
        .id_c_rfw(id_c_rfw), .id_c_drw(id_c_drw), .id_c_wbsource(id_c_wbsource),
        .id_c_alucontrol(id_c_alucontrol), .id_func(id_func),
        .id_rfa(id_rfa), .id_rfb(id_rfb), .id_rfbse(id_rfbse), .id_jalra(id_jalra),
        .id_shamt(id_shamt), .id_rf_waddr(id_rf_waddr),
        .ex_stall(ex_stall), .p_valid(p_valid), .p_c_rfw(p_c_rfw), .p_c_drw(p_c_drw),
        .p_c_wbsource(p_c_wbsource), .p_alu_r(p_alu_r), .p_rfb(p_rfb),
        .p_jalra(p_jalra), .p_rf_waddr(p_rf_waddr), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    // EX/MEM only updates on edges where stall_in was low.
    always @(posedge clk) upd_q <= !stall_in;

    always @(negedge clk) begin
        if (rst && upd_q && p_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: p_alu_r=%h with empty scoreboard", p_alu_r);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (p_alu_r !== e.r || p_c_rfw !== e.rfw) begin
                    errors++;
                    $display("FAIL sb_tag%0d: got r=%h rfw=%b, expected r=%h rfw=%b",
                             e.tag, p_alu_r, p_c_rfw, e.r, e.rfw);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [5:0] ac, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] bse,
                        input logic [4:0] sh, input logic [31:0] er, input logic erfw,
                        input logic [7:0] tag, output int stalls);
        exp_q.push_back('{r: er, rfw: erfw, tag: tag});
        id_valid = 1'b1; id_c_rfw = 1'b1; id_c_alucontrol = ac; id_func = fn;
        id_rfa = a; id_rfb = b; id_rfbse = bse; id_shamt = sh; id_rf_waddr = 5'd3;
        id_jalra = 32'h40;
        stalls = 0;
        #1;
        while (ex_stall && stalls < 200) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 200) begin
            checks++; errors++;
            $display("FAIL stall_timeout_tag%0d: ex_stall still %b after %0d cycles", tag, ex_stall, stalls);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int s;
        logic [5:0] rst_fn;
        // Present a live add during reset so a leaky register shows up.
        id_valid = 1'b1; id_c_rfw = 1'b1; id_c_drw = 1'b1; id_c_wbsource = 2'd2;
        id_func = 6'h21; id_rfa = 32'd5; id_rfb = 32'd7; id_jalra = 32'h44; id_rf_waddr = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_p_alu_r", p_alu_r, 32'd0);
        chk("rst_p_ctrl", {27'd0, p_c_rfw, p_c_drw, p_c_wbsource, 1'b0}, 32'd0);
        chk("rst_p_data", p_rfb | p_jalra | 32'(p_rf_waddr), 32'd0);
        chk("rst_ex_stall", 32'(ex_stall), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        id_valid = 1'b0; id_c_drw = 1'b0; id_c_wbsource = 2'd0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // ALU / shifter vectors
        send(6'h00, 6'h21, 32'd5, 32'd7, 0, 0, 32'd12, 1, 1, s);
        send(6'h00, 6'h23, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1, 2, s);
        send(6'h00, 6'h03, 0, 32'h8000_0000, 0, 5'd4, 32'hF800_0000, 1, 3, s);
        send(6'h00, 6'h06, 32'd36, 32'h0000_00F0, 0, 0, 32'h0000_000F, 1, 4, s);
        send(6'h00, 6'h2a, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 1, 5, s);
        send(6'h00, 6'h2b, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 1, 6, s);
        send(6'h00, 6'h27, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 7, s);
        send(6'h00, 6'h00, 0, 32'h0000_0003, 0, 5'd31, 32'h8000_0000, 1, 8, s);
        send(6'h08, 6'h3f, 32'd10, 0, 32'hFFFF_FFFD, 0, 32'd7, 1, 9, s);
        send(6'h0f, 6'h00, 0, 0, 32'h0000_1234, 0, 32'h1234_0000, 1, 10, s);
        send(6'h0d, 6'h00, 32'h0000_00F0, 0, 32'h0000_000F, 0, 32'h0000_00FF, 1, 11, s);
        send(6'h0a, 6'h00, 32'hFFFF_FFFB, 0, 32'd3, 0, 32'd1, 1, 12, s);
        send(6'h0b, 6'h00, 32'hFFFF_FFFB, 0, 32'd3, 0, 32'd0, 1, 13, s);
        send(6'h2b, 6'h00, 32'h0000_0100, 0, 32'd8, 0, 32'h0000_0108, 1, 14, s);
        send(6'h00, 6'h3f, 32'd1, 32'd2, 0, 0, 32'd0, 1, 15, s);

        // mult -3 x 7, then dependent mfhi/mflo back to back
        send(6'h00, 6'h18, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'd0, 0, 20, s);
        chk("md_busy_after_mult", 32'(md_busy), 32'd1);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 21, s);
        chk("mfhi_stall_cycles", 32'(s), 32'd33);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'hFFFF_FFEB, 1, 22, s);
        chk("mflo_stall_cycles", 32'(s), 32'd0);

`ifdef CPU_EX_DIV_EN
        send(6'h00, 6'h1a, 32'd7, 32'd0, 0, 0, 32'd0, 0, 30, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 31, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd7, 1, 32, s);
        send(6'h00, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 0, 33, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'h8000_0000, 1, 34, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd0, 1, 35, s);
        send(6'h00, 6'h1b, 32'd100, 32'd7, 0, 0, 32'd0, 0, 36, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'd14, 1, 37, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd2, 1, 38, s);
        send(6'h00, 6'h1a, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'd0, 0, 39, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'hFFFF_FFFD, 1, 40, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 41, s);
        rst_fn = 6'h1b;
`else
        send(6'h00, 6'h1a, 32'd7, 32'd0, 0, 0, 32'd0, 0, 30, s);
        chk("nodiv_md_busy", 32'(md_busy), 32'd0);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 31, s);
        chk("nodiv_no_stall", 32'(s), 32'd0);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'hFFFF_FFEB, 1, 32, s);
        rst_fn = 6'h18;
`endif
        send(6'h00, 6'h18, 32'd6, 32'd7, 0, 0, 32'd0, 0, 50, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'd42, 1, 51, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd0, 1, 52, s);
        send(6'h00, 6'h19, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd0, 0, 53, s);
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd1, 1, 54, s);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'hFFFF_FFFE, 1, 55, s);

        // Downstream stall holds EX/MEM
        send(6'h00, 6'h21, 32'd1, 32'd1, 0, 0, 32'd2, 1, 60, s);
        stall_in = 1'b1; id_rfa = 32'd3; id_rfb = 32'd4;
        #1;
        chk("stall_in_ex_stall", 32'(ex_stall), 32'd1);
        @(posedge clk); #1;
        chk("stall_in_hold_r", p_alu_r, 32'd2);
        chk("stall_in_hold_v", 32'(p_valid), 32'd1);
        stall_in = 1'b0;
        send(6'h00, 6'h21, 32'd3, 32'd4, 0, 0, 32'd7, 1, 61, s);

        // Reset mid-iteration aborts and clears HI/LO
        send(6'h00, rst_fn, 32'd1000, 32'd3, 0, 0, 32'd0, 0, 70, s);
        id_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b0;
        #2;
        chk("rst_mid_md_busy", 32'(md_busy), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        send(6'h00, 6'h10, 0, 0, 0, 0, 32'd0, 1, 71, s);
        chk("rst_mid_no_stall", 32'(s), 32'd0);
        send(6'h00, 6'h12, 0, 0, 0, 0, 32'd0, 1, 72, s);
        id_valid = 1'b0;

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
